// File: rtl/sensor_readout.sv
// Delay-sensor readout: counts high samples of delayed_clk over 2^WIN_LOG2 clk cycles.
// Latency: start -> meas_valid after SYNC_STAGES+N+1 edges; continuous results every N cycles.
// Backpressure: result held until meas_ready; a window ending while held is dropped and sets overrun.
// Optional: define SENSOR_READOUT_MINMAX_EN to add min_data/max_data tracking outputs.
module sensor_readout #(
    parameter int WIN_LOG2    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = WIN_LOG2 + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             delayed_clk,
    input  logic             start,
    input  logic             continuous,
    input  logic [CNT_W-1:0] alarm_thresh,
    output logic [CNT_W-1:0] meas_data,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             busy,
    output logic             alarm,
    output logic             overrun
`ifdef SENSOR_READOUT_MINMAX_EN
    ,
    output logic [CNT_W-1:0] min_data,
    output logic [CNT_W-1:0] max_data
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        ACCUM = 2'd2
    } state_t;

    localparam logic [1:0] FLUSH_LAST = 2'(SYNC_STAGES - 1);

    state_t              state;
    logic [SYNC_STAGES:0] sync_q;
    logic                s;
    logic [1:0]          flush_cnt;
    logic [WIN_LOG2-1:0] win_cnt;
    logic [CNT_W-1:0]    acc;
    logic [CNT_W-1:0]    acc_next;
    logic                done;
    logic [CNT_W-1:0]    result;
    logic                start_ok;
    logic                load;

    assign s        = sync_q[SYNC_STAGES];
    assign acc_next = acc + {{(CNT_W-1){1'b0}}, s};
    assign start_ok = (state == IDLE) && start;
    // A finished window can be taken if the slot is empty or being emptied this cycle.
    assign load     = done && (!meas_valid || meas_ready);

    // Capture flop plus synchroniser chain; free-running so the chain is always warm.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-1:0], delayed_clk};
        end
    end

    // Measurement FSM: flush stale synchroniser data, then accumulate N samples per window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            flush_cnt <= '0;
            win_cnt   <= '0;
            acc       <= '0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    flush_cnt <= '0;
                    win_cnt   <= '0;
                    acc       <= '0;
                    if (start) begin
                        state <= FLUSH;
                        busy  <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state   <= ACCUM;
                        win_cnt <= '0;
                        acc     <= '0;
                    end else begin
                        flush_cnt <= flush_cnt + 2'd1;
                    end
                end
                ACCUM: begin
                    win_cnt <= win_cnt + 1'b1;
                    acc     <= acc_next;
                    if (win_cnt == '1) begin
                        // Last cycle: the sum including this cycle's sample is the result.
                        done   <= 1'b1;
                        result <= acc_next;
                        acc    <= '0;
                        if (!continuous) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output register with valid/ready handshake, alarm compare and sticky overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meas_data  <= '0;
            meas_valid <= 1'b0;
            alarm      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (start_ok) begin
                overrun <= 1'b0;
            end
            if (meas_valid && meas_ready) begin
                meas_valid <= 1'b0;
            end
            if (load) begin
                meas_data  <= result;
                meas_valid <= 1'b1;
                alarm      <= (result < alarm_thresh);
            end else if (done) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef SENSOR_READOUT_MINMAX_EN
    logic [CNT_W-1:0] min_base;
    logic [CNT_W-1:0] max_base;

    assign min_base = start_ok ? '1 : min_data;
    assign max_base = start_ok ? '0 : max_data;

    // Running extremes of loaded results; restarted by each accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            min_data <= '1;
            max_data <= '0;
        end else if (load) begin
            min_data <= (result < min_base) ? result : min_base;
            max_data <= (result > max_base) ? result : max_base;
        end else begin
            min_data <= min_base;
            max_data <= max_base;
        end
    end
`endif

endmodule

// File: tb/tb_sensor_readout.sv
// Self-checking bench for sensor_readout (WIN_LOG2=8, SYNC_STAGES=2).
// Model: a result equals the count of ones in delayed_clk as sampled at the N edges
// starting with the edge that accepted start (next window starts N edges later).
module tb_sensor_readout;

    localparam int WIN_LOG2 = 8;
    localparam int SS       = 2;
    localparam int N        = 1 << WIN_LOG2;
    localparam int CNT_W    = WIN_LOG2 + 1;
    localparam int LAT      = SS + N + 1;

    logic             clk;
    logic             rst_n;
    logic             delayed_clk;
    logic             start;
    logic             continuous;
    logic [CNT_W-1:0] alarm_thresh;
    logic [CNT_W-1:0] meas_data;
    logic             meas_valid;
    logic             meas_ready;
    logic             busy;
    logic             alarm;
    logic             overrun;
`ifdef SENSOR_READOUT_MINMAX_EN
    logic [CNT_W-1:0] min_data;
    logic [CNT_W-1:0] max_data;
`endif

    sensor_readout #(.WIN_LOG2(WIN_LOG2), .SYNC_STAGES(SS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .delayed_clk  (delayed_clk),
        .start        (start),
        .continuous   (continuous),
        .alarm_thresh (alarm_thresh),
        .meas_data    (meas_data),
        .meas_valid   (meas_valid),
        .meas_ready   (meas_ready),
        .busy         (busy),
        .alarm        (alarm),
        .overrun      (overrun)
`ifdef SENSOR_READOUT_MINMAX_EN
        ,
        .min_data     (min_data),
        .max_data     (max_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record the delayed_clk value seen at every rising edge.
    bit hist[$];
    always @(posedge clk) hist.push_back(delayed_clk);

    int n_vec = 0;
    int n_err = 0;
    int pat   = 0;   // 0: const 0, 1: const 1, 2: toggle, 3: random

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_dclk();
        case (pat)
            0:       delayed_clk = 1'b0;
            1:       delayed_clk = 1'b1;
            2:       delayed_clk = ~delayed_clk;
            default: delayed_clk = 1'($urandom_range(0, 1));
        endcase
    endtask

    function automatic int model_sum(input int t0);
        int sum = 0;
        for (int i = 0; i < N; i++)
            if (t0 + i < hist.size()) sum += int'(hist[t0 + i]);
        return sum;
    endfunction

    // Pulse start for one edge; t0 is the index of the edge that saw it.
    task automatic start_run(output int t0);
        start = 1'b1;
        tick();
        t0 = hist.size() - 1;
        start = 1'b0;
        drive_dclk();
    endtask

    typedef struct {
        int pat;
        int thr;
        int exp_data;
        int exp_alarm;
        bit use_model;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int t0, t1, lat, bfall, data, alm, exp_d, exp_a, nv, extra, first, d0, ov514, unstable;
        int vt[3];
        int vd[3];

        rst_n = 1'b0; delayed_clk = 1'b0; start = 1'b0; continuous = 1'b0;
        alarm_thresh = '0; meas_ready = 1'b0;

        tbl[0] = '{1, 128, 256, 0, 1'b0};
        tbl[1] = '{0, 128,   0, 1, 1'b0};
        tbl[2] = '{0,   0,   0, 0, 1'b0};
        tbl[3] = '{1, 257, 256, 1, 1'b0};
        tbl[4] = '{1, 256, 256, 0, 1'b0};
        tbl[5] = '{0,   1,   0, 1, 1'b0};
        tbl[6] = '{2, 128, 128, 0, 1'b1};
        tbl[7] = '{3, int'($urandom_range(0, 300)), 0, 0, 1'b1};
        tbl[8] = '{3, int'($urandom_range(100, 160)), 0, 0, 1'b1};
        tbl[9] = '{3, int'($urandom_range(120, 140)), 0, 0, 1'b1};

        // Reset state
        repeat (3) tick();
        check("rst_valid", int'(meas_valid), 0);
        check("rst_data", int'(meas_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_alarm", int'(alarm), 0);
        check("rst_overrun", int'(overrun), 0);
`ifdef SENSOR_READOUT_MINMAX_EN
        check("rst_min", int'(min_data), (1 << CNT_W) - 1);
        check("rst_max", int'(max_data), 0);
`endif
        rst_n = 1'b1;
        tick();

        // Table-driven single windows
        for (int r = 0; r < 10; r++) begin
            pat = tbl[r].pat; continuous = 1'b0; meas_ready = 1'b1;
            alarm_thresh = CNT_W'(tbl[r].thr);
            drive_dclk();
            start_run(t0);
            lat = -1; bfall = -1; data = -1; alm = -1;
            for (int j = 1; j <= 400 && lat < 0; j++) begin
                tick();
                drive_dclk();
                if (bfall < 0 && !busy) bfall = j;
                if (meas_valid) begin
                    lat = j; data = int'(meas_data); alm = int'(alarm);
                end
            end
            exp_d = tbl[r].use_model ? model_sum(t0) : tbl[r].exp_data;
            exp_a = tbl[r].use_model ? int'(exp_d < tbl[r].thr) : tbl[r].exp_alarm;
            check($sformatf("row%0d_latency", r), lat, LAT);
            check($sformatf("row%0d_busy_fall", r), bfall, LAT - 1);
            check($sformatf("row%0d_data", r), data, exp_d);
            check($sformatf("row%0d_alarm", r), alm, exp_a);
            if (tbl[r].pat == 2)
                check("toggle_near_half", int'(data >= 127 && data <= 129), 1);
            repeat (3) tick();
        end

        // Three continuous windows, continuous dropped during the third
        pat = 3; continuous = 1'b1; meas_ready = 1'b1;
        alarm_thresh = CNT_W'($urandom_range(100, 160));
        drive_dclk();
        start_run(t0);
        nv = 0; vt = '{-1, -1, -1}; vd = '{-1, -1, -1};
        for (int j = 1; j <= 900 && nv < 3; j++) begin
            tick();
            drive_dclk();
            if (meas_valid) begin
                vt[nv] = j; vd[nv] = int'(meas_data); nv++;
                if (nv == 2) continuous = 1'b0;
            end
        end
        check("cont_count", nv, 3);
        check("cont_first", vt[0], LAT);
        check("cont_gap1", vt[1] - vt[0], N);
        check("cont_gap2", vt[2] - vt[1], N);
        for (int k = 0; k < 3; k++)
            check($sformatf("cont_data%0d", k), vd[k], model_sum(t0 + k * N));
        extra = 0;
        for (int j = 0; j < 300; j++) begin
            tick();
            if (meas_valid) extra++;
        end
        check("cont_stop_extra", extra, 0);
        check("cont_stop_busy", int'(busy), 0);

        // Backpressure: second window dropped, overrun sticky until next start
        pat = 3; continuous = 1'b1; meas_ready = 1'b0;
        alarm_thresh = CNT_W'(128);
        drive_dclk();
        start_run(t0);
        first = -1; d0 = -1; ov514 = -1; unstable = 0;
        for (int j = 1; j <= 515; j++) begin
            tick();
            drive_dclk();
            if (first < 0 && meas_valid) begin
                first = j; d0 = int'(meas_data);
            end else if (first >= 0 && (!meas_valid || int'(meas_data) != d0)) begin
                unstable++;
            end
            if (j == 514) ov514 = int'(overrun);
        end
        check("ovr_first", first, LAT);
        check("ovr_data0", d0, model_sum(t0));
        check("ovr_not_early", ov514, 0);
        check("ovr_held_stable", unstable, 0);
        check("ovr_set", int'(overrun), 1);
        check("ovr_data_kept", int'(meas_data), d0);
        continuous = 1'b0;
        meas_ready = 1'b1;
        tick();
        drive_dclk();
        check("ovr_handshake_clears", int'(meas_valid), 0);
        first = -1; data = -1;
        for (int j = 517; j <= 800 && first < 0; j++) begin
            tick();
            drive_dclk();
            if (meas_valid) begin
                first = j; data = int'(meas_data);
            end
        end
        check("ovr_third_time", first, LAT + 2 * N);
        check("ovr_third_data", data, model_sum(t0 + 2 * N));
        tick();
        check("ovr_sticky_idle", int'(overrun), 1);
        start_run(t1);
        check("ovr_cleared_by_start", int'(overrun), 0);
        for (int j = 0; j < 300 && busy; j++) tick();
        repeat (3) tick();

        // Start while busy is ignored; then reset in the middle of a window
        pat = 1; continuous = 1'b0; meas_ready = 1'b0; alarm_thresh = CNT_W'(300);
        drive_dclk();
        start_run(t0);
        lat = -1; bfall = -1;
        for (int j = 1; j <= 400 && lat < 0; j++) begin
            tick();
            start = (j == 50);
            if (bfall < 0 && !busy) bfall = j;
            if (meas_valid) lat = j;
        end
        start = 1'b0;
        check("busy_start_latency", lat, LAT);
        check("busy_start_fall", bfall, LAT - 1);
        check("busy_start_data", int'(meas_data), 256);
        check("busy_start_alarm", int'(alarm), 1);
        start_run(t1);
        repeat (SS + 100) tick();
        check("pre_rst_busy", int'(busy), 1);
        check("pre_rst_valid", int'(meas_valid), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", int'(meas_valid), 0);
        check("mid_rst_data", int'(meas_data), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_alarm", int'(alarm), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        extra = 0;
        for (int j = 0; j < 300; j++) begin
            tick();
            if (meas_valid || busy) extra++;
        end
        check("mid_rst_discarded", extra, 0);

`ifdef SENSOR_READOUT_MINMAX_EN
        // All-ones window followed by all-zeros window
        pat = 1; continuous = 1'b1; meas_ready = 1'b1; alarm_thresh = '0;
        drive_dclk();
        start_run(t0);
        nv = 0;
        for (int j = 1; j <= 700 && nv < 2; j++) begin
            tick();
            if (j == N - 1) pat = 0;
            drive_dclk();
            if (meas_valid) begin
                nv++;
                continuous = 1'b0;
            end
        end
        check("mm_count", nv, 2);
        check("mm_min", int'(min_data), 0);
        check("mm_max", int'(max_data), 256);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sensor_readout.md
Name: sensor_readout

Overview:
Receive-side companion to the inverter-chain delay sensor. Samples the sensor's delayed_clk output on the system clock and counts high samples over a fixed window of 2^WIN_LOG2 cycles. The count is a digital measure of the chain delay relative to the clock half-period. Each result is presented on a valid/ready interface, with a low-count alarm for glitch/voltage-drop detection; the block sits between the sensor instance and the project's readout logic.

Parameters:
WIN_LOG2, 8, log2 of window length N = 2^WIN_LOG2 samples; legal range 2..16
SYNC_STAGES, 2, synchroniser flops after the capture flop; legal range 1..3
CNT_W, WIN_LOG2+1, derived result width; not overridden

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  synchronous active-low reset
delayed_clk  input  1  sensor output, asynchronous to clk
start  input  1  begin measurement; sampled only in IDLE
continuous  input  1  1 = back-to-back windows; sampled at each window end
alarm_thresh  input  CNT_W  alarm when result < this value
meas_data  output  CNT_W  count of high samples in the last accepted window
meas_valid  output  1  result available
meas_ready  input  1  consumer accepts result
busy  output  1  FSM not in IDLE
alarm  output  1  loaded result < alarm_thresh
overrun  output  1  sticky: a completed window was dropped

Behaviour:
- Reset is synchronous, active-low. Reset applies on any rising clk edge with rst_n=0, including mid-window; the in-progress window is discarded. Reset values: meas_data=0, meas_valid=0, busy=0, alarm=0, overrun=0, FSM=IDLE, counters=0, capture and sync flops=0.
- Sampling path: capture flop plus SYNC_STAGES flops, always running. Only the last sync flop output (s) feeds the accumulator.
- FSM states:
  - IDLE: start=1 -> FLUSH. Also clears overrun and resets the flush counter.
  - FLUSH: lasts SYNC_STAGES cycles, with no accumulation, so data captured before start is flushed. Then -> ACCUM.
  - ACCUM: lasts exactly N cycles. Each cycle: acc += s, and the window counter increments. On the last cycle the final sum (including that cycle's s) is the result. Then continuous=1 -> ACCUM (acc and window counter reset, no flush), else -> IDLE.
- Latency: start seen in IDLE at edge T gives meas_valid=1 after edge T+SYNC_STAGES+N+1. In continuous mode, results follow every N cycles.
- busy = (state != IDLE). start while busy is ignored.
- Result range is 0..N. CNT_W bits hold N without wrap; all-ones input gives exactly N.
- Output register, at window end:
  - If meas_valid=0, or meas_valid=1 with meas_ready=1 that same cycle: load meas_data, set meas_valid=1, and load alarm = (result < alarm_thresh), an unsigned compare using alarm_thresh sampled that cycle.
  - Otherwise the new result is dropped, meas_data/alarm are unchanged, and overrun is set.
- Handshake: meas_valid stays high and meas_data stays stable until meas_valid & meas_ready at an edge. That edge clears meas_valid unless a simultaneous window end reloads it (back-to-back valid allowed).
- overrun stays set until reset or the next start accepted in IDLE.
- continuous dropped mid-window: the current window completes and its result is presented, then -> IDLE.
- alarm_thresh=0 means alarm is never raised. alarm_thresh > N means alarm is always raised.

Optional Feature:
SENSOR_READOUT_MINMAX_EN
- Defined: adds outputs min_data and max_data (CNT_W each). Both update on every result load: min_data = min(min_data, result), max_data = max(max_data, result).
- Reset values and values on start accepted in IDLE: min_data = all-ones, max_data = 0. Dropped results do not update them.
- Not defined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- WIN_LOG2=8, SYNC_STAGES=2, delayed_clk=1, alarm_thresh=128, pulse start at edge T, meas_ready=1 -> meas_valid high after edge T+259, meas_data=256, alarm=0, busy low after edge T+258.
- delayed_clk=0, same setup -> meas_data=0, alarm=1. Then alarm_thresh=0 with a new run -> alarm=0.
- delayed_clk toggling every clk cycle (phase-locked) -> meas_data=128 ±1. Three continuous windows -> three valid results, 256 cycles apart.
- continuous=1, meas_ready=0 -> first result held at its value, second window end sets overrun=1 with meas_data unchanged. Then meas_ready=1 -> meas_valid drops after one handshake. A new start in IDLE clears overrun.
- rst_n=0 for one edge at window cycle 100 -> next cycle all outputs at reset values, FSM IDLE. A start during busy is ignored (busy window length unchanged).
- With SENSOR_READOUT_MINMAX_EN, delayed_clk=1 window then delayed_clk=0 window -> min_data=0, max_data=256. Without the macro the build has no min_data/max_data ports.
